// File: rtl/instruction_encoder_loader.sv
// Packs field-level instruction descriptors into 20-bit words and writes them to consecutive addresses.
// Optional running XOR checksum of written words is enabled by defining LOADER_CHECKSUM_EN.
module instruction_encoder_loader #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [4:0]  opcode,
  input  logic [3:0]  dr,
  input  logic [3:0]  sr1,
  input  logic [3:0]  sr2,
  input  logic [19:0] imm,
  input  logic [9:0]  addr,
  input  logic        last,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [19:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        full,
  output logic        err,
  output logic [10:0] count,
  output logic [19:0] checksum
);

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE_S, FULL_S, ERR_S} state_t;

  localparam logic [9:0] LAST_ADDR = 10'(MEM_DEPTH - 1);

  state_t      state;
  logic        last_r;
  logic        imm_ok;
  logic [19:0] word;

  // A 20-bit value fits in [-64, 63] exactly when bits [19:6] are a pure sign extension.
  always_comb begin
    imm_ok = (imm[19:6] == 14'h0000) || (imm[19:6] == 14'h3FFF);
    word   = '0;
    case (fmt)
      2'd0:    word = {opcode, dr, sr1, sr2, 3'b000};
      2'd1:    word = {opcode, dr, sr1, imm[6:0]};
      2'd2:    word = {opcode, 5'b00000, addr};
      default: word = {opcode, 15'h0000};
    endcase
  end

  assign in_ready = (state == ACCEPT);
  assign mem_we   = (state == WRITE);
  assign busy     = (state == ACCEPT) || (state == WRITE);

  // start overrides everything, including an ack arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_r    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      done      <= 1'b0;
      full      <= 1'b0;
      err       <= 1'b0;
    end else if (start) begin
      mem_addr <= base_addr;
      count    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      if ({1'b0, base_addr} >= 11'(MEM_DEPTH)) begin
        full  <= 1'b1;
        state <= FULL_S;
      end else begin
        full  <= 1'b0;
        state <= ACCEPT;
      end
    end else begin
      case (state)
        ACCEPT: begin
          if (in_valid) begin
            if (fmt == 2'd1 && !imm_ok) begin
              err   <= 1'b1;
              state <= ERR_S;
            end else begin
              mem_wdata <= word;
              last_r    <= last;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            count <= count + 11'd1;
            if (last_r) begin
              done <= 1'b1;
              if (mem_addr == LAST_ADDR) full <= 1'b1;
              state <= DONE_S;
            end else if (mem_addr == LAST_ADDR) begin
              full  <= 1'b1;
              state <= FULL_S;
            end else begin
              mem_addr <= mem_addr + 10'd1;
              state    <= ACCEPT;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic ack_fire;
  assign ack_fire = (state == WRITE) && mem_ack && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           checksum <= '0;
    else if (start)    checksum <= '0;
    else if (ack_fire) checksum <= checksum ^ mem_wdata;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Self-checking bench for instruction_encoder_loader: directed sequences, a vector table and randomized programs.
module tb_instruction_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, last;
  logic [9:0]  base_addr, addr, mem_addr;
  logic [1:0]  fmt;
  logic [4:0]  opcode;
  logic [3:0]  dr, sr1, sr2;
  logic [19:0] imm, mem_wdata, checksum;
  logic        mem_we, mem_ack, busy, done, full, err;
  logic [10:0] count;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  opcode;
    logic [3:0]  dr;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic [19:0] imm;
    logic [9:0]  addr;
    logic        last;
  } desc_t;

  typedef struct {
    desc_t       d;
    logic [19:0] word;
    bit          is_err;
  } vec_t;

  instruction_encoder_loader #(.MEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .dr(dr), .sr1(sr1), .sr2(sr2), .imm(imm), .addr(addr), .last(last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .full(full), .err(err), .count(count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder built from field weights; returns 0 when an I-format immediate is out of range.
  function automatic bit model_encode(input desc_t d, output logic [19:0] w);
    int v;
    int acc;
    bit legal;
    legal = 1'b1;
    acc = int'(d.opcode) * 32768;
    case (d.fmt)
      2'd0: acc += int'(d.dr) * 2048 + int'(d.sr1) * 128 + int'(d.sr2) * 8;
      2'd1: begin
        v = int'(d.imm);
        if (v >= 524288) v -= 1048576;
        legal = (v >= -64) && (v <= 63);
        acc += int'(d.dr) * 2048 + int'(d.sr1) * 128 + ((v + 128) % 128);
      end
      2'd2: acc += int'(d.addr);
      default: ;
    endcase
    w = acc[19:0];
    return legal;
  endfunction

  function automatic desc_t mk(input int f, input int op, input int d_r, input int s1, input int s2,
                               input int im, input int ad, input bit lst);
    desc_t d;
    d.fmt = f[1:0]; d.opcode = op[4:0]; d.dr = d_r[3:0]; d.sr1 = s1[3:0]; d.sr2 = s2[3:0];
    d.imm = im[19:0]; d.addr = ad[9:0]; d.last = lst;
    return d;
  endfunction

  task automatic pulse_start(input int base);
    base_addr = base[9:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input desc_t d, output bit ok);
    fmt = d.fmt; opcode = d.opcode; dr = d.dr; sr1 = d.sr1; sr2 = d.sr2;
    imm = d.imm; addr = d.addr; last = d.last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check_output("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_refused(input desc_t d);
    fmt = d.fmt; opcode = d.opcode; imm = d.imm; last = d.last;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_output("refused_in_ready", 32'(in_ready), 32'd0);
      check_output("refused_mem_we", 32'(mem_we), 32'd0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Hold the ack low for 'delay' cycles of mem_we, checking the write stays stable, then ack once.
  task automatic write_phase(input int delay, input int exp_addr, input logic [19:0] exp_word);
    for (int i = 0; i <= delay; i++) begin
      check_output("wr_mem_we", 32'(mem_we), 32'd1);
      check_output("wr_mem_addr", 32'(mem_addr), 32'(exp_addr));
      check_output("wr_mem_wdata", 32'(mem_wdata), 32'(exp_word));
      if (i == delay) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
  endtask

  function automatic logic [19:0] exp_cs(input logic [19:0] v);
`ifdef LOADER_CHECKSUM_EN
    return v;
`else
    return (v & 20'h0);
`endif
  endfunction

  task automatic run_random(input int iter);
    int base, n, m_addr, m_count, dly;
    bit m_done, m_full, m_err, stopped, ok, legal;
    logic [19:0] m_cs, w;
    desc_t d;
    int v;
    base = (iter % 3 == 0) ? 1019 + int'($urandom_range(0, 4)) : int'($urandom_range(0, 1023));
    pulse_start(base);
    m_addr = base; m_count = 0; m_cs = '0;
    m_done = 0; m_full = 0; m_err = 0; stopped = 0;
    n = int'($urandom_range(1, 6));
    for (int k = 0; k < n; k++) begin
      d.fmt = 2'($urandom_range(0, 3)); d.opcode = 5'($urandom);
      d.dr = 4'($urandom); d.sr1 = 4'($urandom); d.sr2 = 4'($urandom);
      d.addr = 10'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        v = int'($urandom_range(0, 140)) - 70;
        d.imm = v[19:0];
      end else begin
        d.imm = 20'($urandom);
      end
      d.last = (k == n - 1) ? 1'($urandom) : ($urandom_range(0, 7) == 0);
      if (stopped) begin
        expect_refused(d);
        continue;
      end
      apply_stimulus(d, ok);
      if (!ok) return;
      legal = model_encode(d, w);
      if (!legal) begin
        m_err = 1; stopped = 1;
        check_output("rnd_err_no_we", 32'(mem_we), 32'd0);
        continue;
      end
      dly = int'($urandom_range(0, 2));
      write_phase(dly, m_addr, w);
      m_count++;
      m_cs ^= w;
      if (d.last) begin
        m_done = 1; stopped = 1;
        if (m_addr == 1023) m_full = 1;
      end else if (m_addr == 1023) begin
        m_full = 1; stopped = 1;
      end else begin
        m_addr++;
      end
    end
    check_output("rnd_count", 32'(count), 32'(m_count));
    check_output("rnd_mem_addr", 32'(mem_addr), 32'(m_addr));
    check_output("rnd_done", 32'(done), 32'(m_done));
    check_output("rnd_full", 32'(full), 32'(m_full));
    check_output("rnd_err", 32'(err), 32'(m_err));
    check_output("rnd_in_ready", 32'(in_ready), 32'(!stopped));
    check_output("rnd_checksum", 32'(checksum), 32'(exp_cs(m_cs)));
  endtask

  initial begin
    vec_t vecs[8];
    bit ok;
    logic [19:0] wm;
    bit lm;

    vecs[0] = '{d: mk(0, 2, 3, 4, 1, 0, 0, 1),             word: 20'h11A08, is_err: 0};
    vecs[1] = '{d: mk(1, 5, 1, 2, 0, 20'hFFFFF, 0, 1),     word: 20'h2897F, is_err: 0};
    vecs[2] = '{d: mk(2, 13, 0, 0, 0, 0, 11, 1),           word: 20'h6800B, is_err: 0};
    vecs[3] = '{d: mk(3, 17, 9, 9, 9, 5, 700, 1),          word: 20'h88000, is_err: 0};
    vecs[4] = '{d: mk(1, 0, 0, 0, 0, 20'hFFFC0, 0, 1),     word: 20'h00040, is_err: 0};
    vecs[5] = '{d: mk(1, 1, 15, 15, 0, 63, 0, 1),          word: 20'h0FFBF, is_err: 0};
    vecs[6] = '{d: mk(0, 31, 15, 15, 15, 20'hFFFFF, 1023, 1), word: 20'hFFFF8, is_err: 0};
    vecs[7] = '{d: mk(1, 3, 2, 2, 0, 20'hFFFBF, 0, 1),     word: 20'h00000, is_err: 1};

    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; last = 1'b0;
    fmt = '0; opcode = '0; dr = '0; sr1 = '0; sr2 = '0; imm = '0; addr = '0; mem_ack = 1'b0;
    tick();
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_output("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_flags", 32'({done, full, err}), 32'd0);
    check_output("rst_count", 32'(count), 32'd0);
    check_output("rst_checksum", 32'(checksum), 32'd0);
    rst = 1'b0;
    tick();
    check_output("idle_in_ready", 32'(in_ready), 32'd0);

    // R then I program with a delayed ack on the first write
    pulse_start(0);
    check_output("accept_busy", 32'(busy), 32'd1);
    apply_stimulus(mk(0, 2, 3, 4, 1, 0, 0, 0), ok);
    write_phase(2, 0, 20'h11A08);
    check_output("r_count", 32'(count), 32'd1);
    check_output("r_in_ready", 32'(in_ready), 32'd1);
    apply_stimulus(mk(1, 5, 1, 2, 0, 20'hFFFFF, 0, 1), ok);
    write_phase(0, 1, 20'h2897F);
    check_output("i_done", 32'(done), 32'd1);
    check_output("i_in_ready", 32'(in_ready), 32'd0);
    check_output("i_count", 32'(count), 32'd2);
    check_output("i_checksum", 32'(checksum), 32'(exp_cs(20'h39377)));

    // A then N program
    pulse_start(16);
    check_output("restart_done", 32'(done), 32'd0);
    apply_stimulus(mk(2, 13, 0, 0, 0, 0, 11, 0), ok);
    write_phase(1, 16, 20'h6800B);
    apply_stimulus(mk(3, 17, 0, 0, 0, 0, 0, 1), ok);
    write_phase(0, 17, 20'h88000);
    check_output("an_done", 32'(done), 32'd1);

    // Out-of-range immediate consumes the descriptor without writing
    pulse_start(32);
    apply_stimulus(mk(1, 4, 1, 1, 0, 64, 0, 0), ok);
    check_output("range_err", 32'(err), 32'd1);
    check_output("range_no_we", 32'(mem_we), 32'd0);
    check_output("range_count", 32'(count), 32'd0);
    check_output("range_addr", 32'(mem_addr), 32'd32);
    tick();
    check_output("range_no_we2", 32'(mem_we), 32'd0);

    // End-of-memory boundary
    pulse_start(1022);
    apply_stimulus(mk(3, 1, 0, 0, 0, 0, 0, 0), ok);
    write_phase(0, 1022, 20'h08000);
    apply_stimulus(mk(3, 2, 0, 0, 0, 0, 0, 0), ok);
    write_phase(1, 1023, 20'h10000);
    check_output("full_flag", 32'(full), 32'd1);
    check_output("full_done", 32'(done), 32'd0);
    check_output("full_count", 32'(count), 32'd2);
    expect_refused(mk(3, 3, 0, 0, 0, 0, 0, 0));

    // last on the final address sets both done and full
    pulse_start(1023);
    apply_stimulus(mk(3, 4, 0, 0, 0, 0, 0, 1), ok);
    write_phase(0, 1023, 20'h20000);
    check_output("both_flags", 32'({done, full}), 32'd3);

    // start during WRITE aborts; a coincident ack is ignored
    pulse_start(48);
    apply_stimulus(mk(0, 1, 1, 1, 1, 0, 0, 0), ok);
    check_output("abort_we_before", 32'(mem_we), 32'd1);
    tick();
    base_addr = 10'h200; start = 1'b1; mem_ack = 1'b1;
    tick();
    start = 1'b0; mem_ack = 1'b0;
    check_output("abort_we", 32'(mem_we), 32'd0);
    check_output("abort_count", 32'(count), 32'd0);
    check_output("abort_addr", 32'(mem_addr), 32'h200);
    check_output("abort_in_ready", 32'(in_ready), 32'd1);
    check_output("abort_checksum", 32'(checksum), 32'd0);

    // Asynchronous reset in the middle of a write
    apply_stimulus(mk(0, 1, 1, 1, 1, 0, 0, 0), ok);
    check_output("arst_we_before", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_output("arst_we", 32'(mem_we), 32'd0);
    check_output("arst_addr", 32'(mem_addr), 32'd0);
    #2 rst = 1'b0;
    tick();

    // Single-descriptor vector table
    for (int i = 0; i < 8; i++) begin
      lm = model_encode(vecs[i].d, wm);
      pulse_start(5);
      apply_stimulus(vecs[i].d, ok);
      if (vecs[i].is_err) begin
        check_output($sformatf("vec%0d_err", i), 32'(err), 32'd1);
        check_output($sformatf("vec%0d_no_we", i), 32'(mem_we), 32'd0);
      end else begin
        write_phase(i % 3, 5, vecs[i].word);
        check_output($sformatf("vec%0d_done", i), 32'(done), 32'd1);
      end
      check_output($sformatf("vec%0d_model", i), 32'(lm), 32'(!vecs[i].is_err));
    end

    for (int it = 0; it < 40; it++) run_random(it);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
